pb_audio_io: RTL and testbench
==============================

Name: pb_audio_io

Overview:
- Port-mapped I/O peripheral on the PicoBlaze port bus.
- Consumes the CPU's port_id, write_strobe, out_port and read_strobe; produces its in_port and interrupt.
- Buffers captured audio samples in a FIFO for the CPU to drain, and pushes CPU-written playback samples to the audio output path.
- Raises an interrupt when the FIFO reaches a programmable threshold or overflows.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (depth 16).
- BASE_ADDR, 8'h00, port base address; port_id[7:3] must equal BASE_ADDR[7:3], and port_id[2:0] selects the register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- port_id  in  8  PicoBlaze port address
- write_strobe  in  1  PicoBlaze output strobe
- out_port  in  8  PicoBlaze output data
- read_strobe  in  1  PicoBlaze input strobe
- in_port  out  8  registered read data to PicoBlaze
- interrupt  out  1  interrupt request to PicoBlaze
- interrupt_ack  in  1  PicoBlaze interrupt acknowledge
- cap_valid  in  1  one-cycle strobe: capture sample available
- cap_data  in  8  capture sample
- play_data  out  8  playback sample register
- play_valid  out  1  one-cycle pulse when play_data is written

Behaviour:
- Reset values: in_port=0, interrupt=0, play_data=0, play_valid=0. FIFO is empty, overflow=0, CTRL=0, THRESH=8.
- Register map (offset from BASE_ADDR):
  - 0 STATUS (R): bit0 empty, bit1 full, bit2 overflow (sticky), bit3 irq_pending; other bits 0.
  - 1 DATA (R): FIFO head.
  - 2 LEVEL (R): zero-extended count, range 0..16.
  - 3 THRESH (R/W).
  - 4 CTRL (R/W): bit0 cap_en, bit1 irq_en, bit2 ovf_clr (write-1, self-clearing, reads 0), bit3 flush (write-1, self-clearing, reads 0).
  - 5 PLAY (W).
  - 6, 7: read 0, writes ignored.
- in_port: registered mux of port_id, one-cycle latency. This is valid because the CPU holds port_id for 2 cycles. An unmatched base address yields 0.
- Pop: read_strobe with DATA selected and FIFO not empty pops one entry. Pop on empty is ignored and DATA reads 0. Reads of other registers have no side effects.
- Write: write_strobe with a matching address updates the register at the next edge.
- PLAY write: play_data=out_port and play_valid=1 for exactly one cycle.
- Push: cap_valid and cap_en.
  - Not full: entry stored.
  - Full: sample dropped and overflow set.
  - Push and pop in the same cycle while full: both happen, level unchanged, no overflow.
- Flush:
  - Pointers and level go to 0 in the cycle after the CTRL write.
  - Flush wins over a same-cycle push or pop; a push dropped this way does not set overflow.
  - Flush leaves overflow unchanged.
- ovf_clr: overflow is set and cleared in the same cycle → set wins.
- Pointer wrap: pointers are FIFO_AW bits and wrap modulo depth. LEVEL is FIFO_AW+1 bits.
- Interrupt:
  - thr_hit = irq_en & (THRESH!=0) & (level >= THRESH).
  - irq_pending sets on the rising edge of thr_hit (registered previous value), or on overflow 0→1 while irq_en.
  - irq_pending clears on interrupt_ack. A set event in the same cycle as interrupt_ack wins.
  - interrupt = irq_pending.
  - Clearing irq_en does not clear a pending request.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); FIFO contents are discarded.

Decomposition:
- Package pb_audio_io_pkg: register offsets (REG_STATUS..REG_PLAY), CTRL/STATUS bit indices, THRESH reset value.
- Sub-module pb_sample_fifo: synchronous FIFO with push/pop/flush, full/empty/level outputs, overflow-drop semantics.
- pb_audio_io itself holds the address decode, registers, read mux and interrupt logic.

Test Plan:
- Reset, then read STATUS and LEVEL → 0x01, 0x00. Read THRESH → 0x08.
- cap_en=1, push 0x10..0x13, read DATA ×4 → 0x10, 0x11, 0x12, 0x13, in order. STATUS → 0x01.
- Push 17 samples with irq_en=0 → LEVEL=16, STATUS=0x06. Write CTRL=0x05 → STATUS=0x02. Write CTRL=0x09 → LEVEL=0, STATUS=0x01.
- THRESH=4, CTRL=0x03, push 4 samples → interrupt rises the cycle after the 4th push. interrupt_ack → interrupt falls next cycle. A 5th push → no new interrupt.
- Full FIFO with a same-cycle push and DATA pop → LEVEL stays 16, overflow stays 0. Read DATA on an empty FIFO → 0x00, LEVEL stays 0.
- Write PLAY=0xA5 → play_data=0xA5, play_valid high exactly 1 cycle. Assert reset mid-push → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pb_audio_io_pkg.sv
// ---------------------------------------------------------------------------
// pb_audio_io_pkg : register map, bit indices and reset constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pb_audio_io_pkg;

  typedef enum logic [2:0] {
    REG_STATUS = 3'd0,
    REG_DATA   = 3'd1,
    REG_LEVEL  = 3'd2,
    REG_THRESH = 3'd3,
    REG_CTRL   = 3'd4,
    REG_PLAY   = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_sel_e;

  localparam int CTRL_CAP_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_OVF_CLR = 2;
  localparam int CTRL_FLUSH   = 3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_IRQ   = 3;

  localparam logic [7:0] THRESH_RST = 8'h08;

endpackage

`default_nettype wire

// File: rtl/pb_audio_io_if.sv
// ---------------------------------------------------------------------------
// pb_audio_io_if : PicoBlaze port bus (CPU is master, peripheral is slave)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pb_audio_io_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, out_port, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, out_port, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

`default_nettype wire

// File: rtl/pb_sample_fifo.sv
// ---------------------------------------------------------------------------
// pb_sample_fifo : sync FIFO, flush beats push/pop, full push is dropped
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pb_sample_fifo #(
  parameter int FIFO_AW = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               push,
  input  wire logic               pop,
  input  wire logic               flush,
  input  wire logic [7:0]         wdata,
  output logic      [7:0]         rdata,
  output logic                    empty,
  output logic                    full,
  output logic      [FIFO_AW:0]   level,
  output logic                    drop
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = count[FIFO_AW];
  assign level = count;
  assign rdata = mem[rptr];

  // A pop frees the slot the same-cycle push needs, so a full FIFO accepts it
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign drop    = push & ~flush & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + FIFO_AW'(1);
      if (do_pop)  rptr <= rptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pb_audio_io.sv
// ---------------------------------------------------------------------------
// pb_audio_io : PicoBlaze audio capture FIFO / playback port with interrupt
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pb_audio_io
  import pb_audio_io_pkg::*;
#(
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pb_audio_io_if.slave    bus,
  input  wire logic       cap_valid,
  input  wire logic [7:0] cap_data,
  output logic      [7:0] play_data,
  output logic            play_valid
);

  logic             hit;
  reg_sel_e         sel;
  logic             wr_thresh, wr_ctrl, wr_play, pop_req;
  logic             ovf_clr, flush;
  logic             cap_en, irq_en, overflow, irq_pending, thr_prev;
  logic [7:0]       thresh;
  logic [7:0]       in_port_q;
  logic [7:0]       rdata;
  logic [7:0]       level_byte;
  logic [7:0]       status;
  logic             thr_hit, irq_set;
  logic [7:0]       fifo_rdata;
  logic             fifo_empty, fifo_full, fifo_drop;
  logic [FIFO_AW:0] fifo_level;

  assign hit       = (bus.port_id[7:3] == BASE_ADDR[7:3]);
  assign sel       = reg_sel_e'(bus.port_id[2:0]);
  assign wr_thresh = bus.write_strobe & hit & (sel == REG_THRESH);
  assign wr_ctrl   = bus.write_strobe & hit & (sel == REG_CTRL);
  assign wr_play   = bus.write_strobe & hit & (sel == REG_PLAY);
  assign pop_req   = bus.read_strobe  & hit & (sel == REG_DATA);
  assign ovf_clr   = wr_ctrl & bus.out_port[CTRL_OVF_CLR];
  assign flush     = wr_ctrl & bus.out_port[CTRL_FLUSH];

  pb_sample_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_valid & cap_en),
    .pop   (pop_req),
    .flush (flush),
    .wdata (cap_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level),
    .drop  (fifo_drop)
  );

  assign level_byte = 8'(fifo_level);

  always_comb begin
    status           = 8'h00;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = overflow;
    status[ST_IRQ]   = irq_pending;
  end

  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (sel)
        REG_STATUS: rdata = status;
        REG_DATA:   rdata = fifo_empty ? 8'h00 : fifo_rdata;
        REG_LEVEL:  rdata = level_byte;
        REG_THRESH: rdata = thresh;
        REG_CTRL:   rdata = {6'b0, irq_en, cap_en};
        default:    rdata = 8'h00;
      endcase
    end
  end

  // Threshold interrupts are edge-triggered so a level parked above THRESH fires once
  assign thr_hit = irq_en & (thresh != 8'h00) & (level_byte >= thresh);
  assign irq_set = (thr_hit & ~thr_prev) | (fifo_drop & ~overflow & irq_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_port_q   <= 8'h00;
      thresh      <= THRESH_RST;
      cap_en      <= 1'b0;
      irq_en      <= 1'b0;
      overflow    <= 1'b0;
      thr_prev    <= 1'b0;
      irq_pending <= 1'b0;
      play_data   <= 8'h00;
      play_valid  <= 1'b0;
    end else begin
      in_port_q  <= rdata;
      thr_prev   <= thr_hit;
      play_valid <= wr_play;
      if (wr_thresh) thresh <= bus.out_port;
      if (wr_ctrl) begin
        cap_en <= bus.out_port[CTRL_CAP_EN];
        irq_en <= bus.out_port[CTRL_IRQ_EN];
      end
      if (wr_play) play_data <= bus.out_port;
      if (fifo_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (irq_set)                irq_pending <= 1'b1;
      else if (bus.interrupt_ack) irq_pending <= 1'b0;
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_pending;

endmodule

`default_nettype wire

// File: tb/tb_pb_audio_io.sv
// ---------------------------------------------------------------------------
// tb_pb_audio_io : directed scoreboard bench for pb_audio_io
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pb_audio_io;

  localparam logic [7:0] BASE = 8'h20;
  localparam logic [7:0] A_STATUS = BASE + 8'd0;
  localparam logic [7:0] A_DATA   = BASE + 8'd1;
  localparam logic [7:0] A_LEVEL  = BASE + 8'd2;
  localparam logic [7:0] A_THRESH = BASE + 8'd3;
  localparam logic [7:0] A_CTRL   = BASE + 8'd4;
  localparam logic [7:0] A_PLAY   = BASE + 8'd5;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cap_valid = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic [7:0] play_data;
  logic       play_valid;
  logic       rs_seen = 1'b0;

  int   tests = 0;
  int   fails = 0;
  exp_t rd_q[$];
  logic [7:0] play_q[$];

  pb_audio_io_if bus();

  pb_audio_io #(.FIFO_AW(4), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .play_data  (play_data),
    .play_valid (play_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: a read completes on the edge that samples read_strobe
  always @(posedge clk) rs_seen <= bus.read_strobe;

  always @(negedge clk) begin
    if (rs_seen) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_read: got 0x%02h, expected no read", bus.in_port);
      end else begin
        exp_t e;
        e = rd_q.pop_front();
        check(e.name, bus.in_port, e.val);
      end
    end
    if (play_valid === 1'b1) begin
      if (play_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL play_valid_extra: got play_valid=1, expected 0");
      end else begin
        check("play_data", play_data, play_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    rd_q.push_back('{name: name, val: exp});
    @(negedge clk) bus.port_id = addr;
    @(negedge clk) bus.read_strobe = 1'b1;
    @(negedge clk) bus.read_strobe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    if (addr == A_PLAY) play_q.push_back(data);
    @(negedge clk) begin
      bus.port_id = addr; bus.out_port = data; bus.write_strobe = 1'b1;
    end
    @(negedge clk) bus.write_strobe = 1'b0;
  endtask

  task automatic push(input logic [7:0] data);
    @(negedge clk) begin cap_valid = 1'b1; cap_data = data; end
    @(negedge clk) cap_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.port_id = 8'h00; bus.out_port = 8'h00;
    bus.write_strobe = 1'b0; bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_in_port", bus.in_port, 8'h00);
    check("rst_interrupt", {7'b0, bus.interrupt}, 8'h00);
    rd(A_STATUS, 8'h01, "rst_status");
    rd(A_LEVEL,  8'h00, "rst_level");
    rd(A_THRESH, 8'h08, "rst_thresh");

    // FIFO order
    wr(A_CTRL, 8'h01);
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) rd(A_DATA, 8'h10 + 8'(i), "fifo_order");
    rd(A_STATUS, 8'h01, "drained_status");

    // Overflow, ovf_clr, flush
    for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
    rd(A_LEVEL,  8'h10, "full_level");
    rd(A_STATUS, 8'h06, "ovf_status");
    wr(A_CTRL, 8'h05);
    rd(A_STATUS, 8'h02, "ovf_clr_status");
    rd(A_CTRL,   8'h01, "ctrl_readback");
    wr(A_CTRL, 8'h09);
    rd(A_LEVEL,  8'h00, "flush_level");
    rd(A_STATUS, 8'h01, "flush_status");

    // Threshold interrupt
    wr(A_THRESH, 8'h04);
    wr(A_CTRL, 8'h03);
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    @(negedge clk);
    check("thr_irq_rise", {7'b0, bus.interrupt}, 8'h01);
    rd(A_STATUS, 8'h08, "irq_status");
    @(negedge clk) bus.interrupt_ack = 1'b1;
    @(negedge clk) bus.interrupt_ack = 1'b0;
    check("irq_ack_fall", {7'b0, bus.interrupt}, 8'h00);
    push(8'h44);
    repeat (3) @(negedge clk);
    check("no_rearm_irq", {7'b0, bus.interrupt}, 8'h00);

    // Full FIFO with same-cycle push and pop
    wr(A_CTRL, 8'h01);
    for (int i = 0; i < 11; i++) push(8'h50 + 8'(i));
    rd(A_LEVEL, 8'h10, "refill_level");
    rd_q.push_back('{name: "pushpop_data", val: 8'h40});
    @(negedge clk) bus.port_id = A_DATA;
    @(negedge clk) begin bus.read_strobe = 1'b1; cap_valid = 1'b1; cap_data = 8'h99; end
    @(negedge clk) begin bus.read_strobe = 1'b0; cap_valid = 1'b0; end
    rd(A_LEVEL,  8'h10, "pushpop_level");
    rd(A_STATUS, 8'h02, "pushpop_no_ovf");
    rd(A_DATA,   8'h41, "pushpop_next_head");

    // Empty pop and decode
    wr(A_CTRL, 8'h09);
    rd(A_DATA,  8'h00, "empty_data");
    rd(A_LEVEL, 8'h00, "empty_level");
    rd(8'h03,   8'h00, "unmatched_base");

    // Playback and asynchronous reset
    wr(A_CTRL, 8'h03);
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    @(negedge clk);
    check("irq_before_rst", {7'b0, bus.interrupt}, 8'h01);
    wr(A_PLAY, 8'hA5);
    @(negedge clk);
    check("play_hold", play_data, 8'hA5);
    check("play_pulse_end", {7'b0, play_valid}, 8'h00);
    @(negedge clk) bus.port_id = A_THRESH;
    @(negedge clk);
    check("in_port_before_rst", bus.in_port, 8'h04);
    cap_valid = 1'b1; cap_data = 8'h77;
    #2 reset = 1'b1;
    #1;
    check("async_in_port", bus.in_port, 8'h00);
    check("async_interrupt", {7'b0, bus.interrupt}, 8'h00);
    check("async_play_data", play_data, 8'h00);
    check("async_play_valid", {7'b0, play_valid}, 8'h00);
    @(negedge clk) cap_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    rd(A_STATUS, 8'h01, "post_rst_status");
    rd(A_LEVEL,  8'h00, "post_rst_level");
    rd(A_THRESH, 8'h08, "post_rst_thresh");

    repeat (3) @(negedge clk);
    tests++;
    if (rd_q.size() != 0 || play_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d reads and %0d plays pending, expected 0",
               rd_q.size(), play_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
